// File: rtl/vector_control_sequencer.sv
// vector_control_sequencer
//
// Multi-cycle control sequencer sitting between instruction fetch and the
// execute/memory stages. One 4-bit opcode is accepted at a time and decoded
// into a registered 12-bit control word. Vector instructions (decoded
// OpType[1] set) are issued as VECTOR_LEN/LANES consecutive chunks, scalar
// instructions as a single chunk, and NOPs retire without issuing at all.
// Each chunk waits for both the memory and execute completion handshakes.
//
// Optional feature: define CTRL_SEQ_TIMEOUT_EN to build a WAIT watchdog.
// After TIMEOUT_CYCLES WAIT cycles without a chunk completing, it sets a
// sticky Error_o, clears the control word and returns to IDLE without Done_o.
// If the macro is undefined, no counter is built and Error_o is tied to 0.
//
// Parameters:
//   LANES          lanes processed per chunk
//   VECTOR_LEN     elements per vector (a multiple of LANES, at least LANES)
//   TIMEOUT_CYCLES watchdog limit in WAIT cycles (used only with the macro)
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   Valid_i        OpCode_i is valid this cycle
//   OpCode_i       instruction opcode
//   Mem_Finished_i memory stage finished the current chunk
//   Exe_Finished_i execute stage finished the current chunk
//   Ready_o        sequencer can accept an opcode (IDLE)
//   Issue_o        one-cycle pulse: Ctrl_o/Chunk_o describe a new chunk
//   Ctrl_o         control word {BranchSelect[11:10], RegFileWE[9],
//                  ExtendSelect[8], ALUSource[7], OpType[6:5],
//                  ALUControl[4:3], MemWE[2], OpSource[1], WBSelect[0]}
//   Chunk_o        current chunk index
//   Done_o         one-cycle pulse: instruction retired
//   Error_o        watchdog fired, sticky until reset

module vector_control_sequencer #(
    parameter int LANES          = 4,
    parameter int VECTOR_LEN     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                Valid_i,
    input  logic [3:0]                          OpCode_i,
    input  logic                                Mem_Finished_i,
    input  logic                                Exe_Finished_i,
    output logic                                Ready_o,
    output logic                                Issue_o,
    output logic [11:0]                         Ctrl_o,
    output logic [$clog2(VECTOR_LEN/LANES):0]   Chunk_o,
    output logic                                Done_o,
    output logic                                Error_o
);

    localparam int NUM_CHUNKS = VECTOR_LEN / LANES;
    localparam int CHUNK_W    = $clog2(NUM_CHUNKS) + 1;
    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [11:0]          ctrl_q;
    logic [CHUNK_W-1:0]   chunk_q;
    logic                 mem_flag_q;
    logic                 exe_flag_q;
    logic                 chunk_done;
    logic                 last_chunk;
    logic                 timeout;
    logic [11:0]          decoded;

    // Opcode to control word table. 1111 decodes to all-zero, which the
    // FSM treats exactly like 0000: a NOP that retires without an issue.
    function automatic logic [11:0] decode(input logic [3:0] op);
        logic [11:0] word;
        case (op)
            4'b0000: word = 12'h000;
            4'b0001: word = 12'h58A;
            4'b0010: word = 12'h98A;
            4'b0011: word = 12'h221;
            4'b0100: word = 12'h261;
            4'b0101: word = 12'h025;
            4'b0110: word = 12'h065;
            4'b0111: word = 12'h262;
            4'b1000: word = 12'h242;
            4'b1001: word = 12'h2A2;
            4'b1010: word = 12'h222;
            4'b1011: word = 12'h22A;
            4'b1100: word = 12'h252;
            4'b1101: word = 12'h25A;
            4'b1110: word = 12'h23A;
            default: word = 12'h000;
        endcase
        return word;
    endfunction

    assign decoded = decode(OpCode_i);

    // A chunk completes when each handshake has been seen at least once
    // during WAIT, either remembered in a flag or arriving this cycle.
    assign chunk_done = (state_q == ST_WAIT)
                      && (mem_flag_q || Mem_Finished_i)
                      && (exe_flag_q || Exe_Finished_i);

    // Scalar instructions are always on their last (only) chunk.
    assign last_chunk = !ctrl_q[6] || (chunk_q == LAST_CHUNK);

`ifdef CTRL_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_cnt_q;
    logic            error_q;

    // wait_cnt_q counts WAIT cycles of the current chunk; the watchdog fires
    // on the TIMEOUT_CYCLES-th WAIT cycle that does not complete the chunk.
    assign timeout = (state_q == ST_WAIT) && !chunk_done
                   && (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
            error_q    <= 1'b0;
        end else begin
            if ((state_q == ST_WAIT) && !chunk_done && !timeout) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end else begin
                wait_cnt_q <= '0;
            end
            if (timeout) begin
                error_q <= 1'b1;
            end
        end
    end

    assign Error_o = error_q;
`else
    assign timeout = 1'b0;
    assign Error_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_d = state_q;
        Ready_o = 1'b0;
        Issue_o = 1'b0;
        Done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                Ready_o = 1'b1;
                if (Valid_i) begin
                    state_d = (decoded == 12'h000) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                Issue_o = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (timeout) begin
                    state_d = ST_IDLE;
                end else if (chunk_done) begin
                    state_d = last_chunk ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                Done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control word and chunk index are loaded at acceptance, held through
    // DONE, and cleared on every return to IDLE so IDLE always shows zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q  <= 12'h000;
            chunk_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Valid_i) begin
                        ctrl_q  <= decoded;
                        chunk_q <= '0;
                    end
                end
                ST_WAIT: begin
                    if (timeout) begin
                        ctrl_q  <= 12'h000;
                        chunk_q <= '0;
                    end else if (chunk_done && !last_chunk) begin
                        chunk_q <= chunk_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    ctrl_q  <= 12'h000;
                    chunk_q <= '0;
                end
                default: begin
                    ctrl_q  <= ctrl_q;
                    chunk_q <= chunk_q;
                end
            endcase
        end
    end

    // Completion flags only live inside WAIT: they are held at zero in every
    // other state, which both ignores early handshakes and guarantees they
    // start clear on each ISSUE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_flag_q <= 1'b0;
            exe_flag_q <= 1'b0;
        end else if ((state_q == ST_WAIT) && !chunk_done && !timeout) begin
            mem_flag_q <= mem_flag_q || Mem_Finished_i;
            exe_flag_q <= exe_flag_q || Exe_Finished_i;
        end else begin
            mem_flag_q <= 1'b0;
            exe_flag_q <= 1'b0;
        end
    end

    assign Ctrl_o  = ctrl_q;
    assign Chunk_o = chunk_q;

endmodule

// File: tb/tb_vector_control_sequencer.sv
// tb_vector_control_sequencer
//
// Self-checking bench for vector_control_sequencer. Directed scenarios
// (scalar, vector, staggered handshakes, NOPs, reset mid-vector, watchdog
// when CTRL_SEQ_TIMEOUT_EN is defined) are followed by randomized opcodes
// and handshake delays. Expected behaviour comes from a transaction-level
// model: the decode table, the chunk count implied by OpType, and the cycle
// at which each chunk completes given its handshake delays.

module tb_vector_control_sequencer;

    localparam int LANES          = 4;
    localparam int VECTOR_LEN     = 16;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int NUM_CHUNKS     = VECTOR_LEN / LANES;
    localparam int CHUNK_W        = $clog2(NUM_CHUNKS) + 1;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic               Valid_i = 1'b0;
    logic [3:0]         OpCode_i = 4'h0;
    logic               Mem_Finished_i = 1'b0;
    logic               Exe_Finished_i = 1'b0;
    logic               Ready_o;
    logic               Issue_o;
    logic [11:0]        Ctrl_o;
    logic [CHUNK_W-1:0] Chunk_o;
    logic               Done_o;
    logic               Error_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_error = 1'b0;
    logic [11:0] ref_table [16];

    vector_control_sequencer #(
        .LANES          (LANES),
        .VECTOR_LEN     (VECTOR_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .Valid_i        (Valid_i),
        .OpCode_i       (OpCode_i),
        .Mem_Finished_i (Mem_Finished_i),
        .Exe_Finished_i (Exe_Finished_i),
        .Ready_o        (Ready_o),
        .Issue_o        (Issue_o),
        .Ctrl_o         (Ctrl_o),
        .Chunk_o        (Chunk_o),
        .Done_o         (Done_o),
        .Error_o        (Error_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic apply_stimulus(input logic valid, input logic [3:0] op,
                                  input logic mem, input logic exe);
        Valid_i        = valid;
        OpCode_i       = op;
        Mem_Finished_i = mem;
        Exe_Finished_i = exe;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, ".ready"}, 32'(Ready_o), 32'd1);
        check_output({tag, ".issue"}, 32'(Issue_o), 32'd0);
        check_output({tag, ".done"},  32'(Done_o),  32'd0);
        check_output({tag, ".ctrl"},  32'(Ctrl_o),  32'h000);
        check_output({tag, ".chunk"}, 32'(Chunk_o), 32'd0);
        check_output({tag, ".error"}, 32'(Error_o), 32'(exp_error));
    endtask

    // Runs one instruction from IDLE back to IDLE. With rand_timing set the
    // handshake delays and the ignored-input noise are random; otherwise the
    // fixed delays (in WAIT cycles after each issue) are used. abort_chunk
    // >= 0 asserts reset during the first WAIT cycle of that chunk.
    task automatic run_op(input logic [3:0] op, input bit rand_timing,
                          input int fixed_dm, input int fixed_de,
                          input int abort_chunk);
        logic [11:0] exp_ctrl;
        int n_exp;
        int dm;
        int de;
        int total;
        logic noise;

        exp_ctrl = ref_table[op];
        if (exp_ctrl == 12'h000) begin
            n_exp = 0;
        end else if (exp_ctrl[6]) begin
            n_exp = NUM_CHUNKS;
        end else begin
            n_exp = 1;
        end

        check_output("accept.ready", 32'(Ready_o), 32'd1);
        apply_stimulus(1'b1, op, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 4'($urandom), 1'b0, 1'b0);

        if (n_exp == 0) begin
            check_output("nop.done",  32'(Done_o),  32'd1);
            check_output("nop.issue", 32'(Issue_o), 32'd0);
            check_output("nop.ctrl",  32'(Ctrl_o),  32'h000);
            check_output("nop.ready", 32'(Ready_o), 32'd0);
            tick();
            check_idle("nop.after");
            return;
        end

        for (int k = 0; k < n_exp; k++) begin
            check_output("issue.pulse", 32'(Issue_o), 32'd1);
            check_output("issue.chunk", 32'(Chunk_o), 32'(k));
            check_output("issue.ctrl",  32'(Ctrl_o),  32'(exp_ctrl));
            check_output("issue.ready", 32'(Ready_o), 32'd0);
            check_output("issue.done",  32'(Done_o),  32'd0);

            noise = rand_timing ? 1'($urandom_range(0, 1)) : 1'b0;
            apply_stimulus(noise, 4'($urandom), noise, noise);
            dm = rand_timing ? int'($urandom_range(0, 3)) : fixed_dm;
            de = rand_timing ? int'($urandom_range(0, 3)) : fixed_de;
            total = (dm > de) ? dm : de;

            if (k == abort_chunk) begin
                tick();
                apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);
                #2 rst_i = 1'b1;
                #1 check_idle("reset.async");
                tick();
                rst_i = 1'b0;
                check_idle("reset.released");
                tick();
                check_idle("reset.after");
                return;
            end

            for (int w = 0; w <= total; w++) begin
                tick();
                check_output("wait.issue", 32'(Issue_o), 32'd0);
                check_output("wait.done",  32'(Done_o),  32'd0);
                check_output("wait.ctrl",  32'(Ctrl_o),  32'(exp_ctrl));
                check_output("wait.chunk", 32'(Chunk_o), 32'(k));
                apply_stimulus(noise && rand_timing ? 1'($urandom_range(0, 1)) : 1'b0,
                               4'($urandom), 1'(w == dm), 1'(w == de));
            end
            tick();
            apply_stimulus(1'b0, 4'($urandom), 1'b0, 1'b0);
        end

        check_output("done.pulse", 32'(Done_o),  32'd1);
        check_output("done.issue", 32'(Issue_o), 32'd0);
        check_output("done.ctrl",  32'(Ctrl_o),  32'(exp_ctrl));
        check_output("done.ready", 32'(Ready_o), 32'd0);
        tick();
        check_idle("done.after");
    endtask

    initial begin
        ref_table[0]  = 12'h000; ref_table[1]  = 12'h58A;
        ref_table[2]  = 12'h98A; ref_table[3]  = 12'h221;
        ref_table[4]  = 12'h261; ref_table[5]  = 12'h025;
        ref_table[6]  = 12'h065; ref_table[7]  = 12'h262;
        ref_table[8]  = 12'h242; ref_table[9]  = 12'h2A2;
        ref_table[10] = 12'h222; ref_table[11] = 12'h22A;
        ref_table[12] = 12'h252; ref_table[13] = 12'h25A;
        ref_table[14] = 12'h23A; ref_table[15] = 12'h000;

        $display("[TB] reset state");
        #1 check_idle("reset.hold");
        tick();
        tick();
        rst_i = 1'b0;
        check_idle("reset.release");

        $display("[TB] scalar add, both finished in first WAIT cycle");
        run_op(4'b1010, 1'b0, 0, 0, -1);

        $display("[TB] vector add over all chunks");
        run_op(4'b0111, 1'b0, 0, 0, -1);

        $display("[TB] staggered handshakes");
        run_op(4'b0011, 1'b0, 0, 3, -1);
        run_op(4'b0100, 1'b0, 2, 1, -1);

        $display("[TB] NOP opcodes");
        run_op(4'b0000, 1'b0, 0, 0, -1);
        run_op(4'b1111, 1'b0, 0, 0, -1);

        $display("[TB] reset in WAIT of chunk 2");
        run_op(4'b0111, 1'b0, 0, 0, 2);
        run_op(4'b1001, 1'b0, 1, 0, -1);

`ifdef CTRL_SEQ_TIMEOUT_EN
        $display("[TB] watchdog with no handshakes");
        apply_stimulus(1'b1, 4'b0100, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);
        check_output("to.issue", 32'(Issue_o), 32'd1);
        for (int w = 0; w < TIMEOUT_CYCLES; w++) begin
            tick();
            check_output("to.wait.error", 32'(Error_o), 32'd0);
            check_output("to.wait.done",  32'(Done_o),  32'd0);
            check_output("to.wait.ready", 32'(Ready_o), 32'd0);
        end
        tick();
        exp_error = 1'b1;
        check_idle("to.fired");
        run_op(4'b1010, 1'b0, 0, 0, -1);
`endif

        $display("[TB] randomized opcodes and handshake delays");
        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom), 1'b1, 0, 0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
